// File: rtl/pipe_stage_if.sv
// pipe_stage_if: fetch-to-decode bundle for pipe_stage_reg; master drives the
// control/fetch side, slave is the stage register.
interface pipe_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int EXC_W   = 5,
    parameter int SIDE_W  = 1
);
    logic               req;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_in;
    logic [EXC_W-1:0]   exc_in;
    logic               slot_in;
    logic [SIDE_W-1:0]  side_in;
    logic               valid_in;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic [EXC_W-1:0]   exc_out;
    logic               slot_out;
    logic [SIDE_W-1:0]  side_out;
    logic               valid_out;

    modport master (
        output req, stall, flush, redirect_pc, instr_in, pc_in, exc_in, slot_in, side_in, valid_in,
        input  instr_out, pc_out, exc_out, slot_out, side_out, valid_out
    );

    modport slave (
        input  req, stall, flush, redirect_pc, instr_in, pc_in, exc_in, slot_in, side_in, valid_in,
        output instr_out, pc_out, exc_out, slot_out, side_out, valid_out
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: fetch/decode boundary register with req > stall > flush > advance priority.
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int                 INSTR_W    = 32,
    parameter int                 PC_W       = 32,
    parameter int                 EXC_W      = 5,
    parameter int                 SIDE_W     = 1,
    parameter int                 HOLD_MODE  = 1,
    parameter logic [PC_W-1:0]    RESET_PC   = 32'h0000_3000,
    parameter logic [PC_W-1:0]    HANDLER_PC = 32'h0000_4180,
    parameter logic [INSTR_W-1:0] NOP_WORD   = '0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                 CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PIPE_STAGE_PERF_EN
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
`endif
    pipe_stage_if.slave      bus
);
    logic               live_q, live_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [EXC_W-1:0]   exc_q, exc_d;
    logic               slot_q, slot_d;
    logic [SIDE_W-1:0]  side_q, side_d;
    logic               valid_q, valid_d;

    always_comb begin
        live_d  = live_q;
        hold_d  = hold_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        slot_d  = slot_q;
        side_d  = side_q;
        valid_d = valid_q;
        if (bus.req) begin
            live_d  = 1'b0;
            hold_d  = NOP_WORD;
            pc_d    = HANDLER_PC;
            exc_d   = '0;
            slot_d  = 1'b0;
            side_d  = '0;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            // First stall cycle latches the memory word before it disappears
            hold_d = live_q ? bus.instr_in : hold_q;
            live_d = 1'b0;
        end else if (bus.flush) begin
            live_d  = 1'b0;
            hold_d  = NOP_WORD;
            pc_d    = bus.redirect_pc;
            exc_d   = bus.exc_in;
            slot_d  = 1'b0;
            side_d  = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = bus.pc_in;
            exc_d   = bus.exc_in;
            slot_d  = bus.slot_in;
            side_d  = bus.side_in;
            valid_d = bus.valid_in;
            live_d  = (HOLD_MODE != 0);
            hold_d  = (HOLD_MODE != 0) ? hold_q : bus.instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            hold_q  <= NOP_WORD;
            pc_q    <= RESET_PC;
            exc_q   <= '0;
            slot_q  <= 1'b0;
            side_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            live_q  <= live_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            slot_q  <= slot_d;
            side_q  <= side_d;
            valid_q <= valid_d;
        end
    end

    assign bus.instr_out = live_q ? bus.instr_in : hold_q;
    assign bus.pc_out    = pc_q;
    assign bus.exc_out   = exc_q;
    assign bus.slot_out  = slot_q;
    assign bus.side_out  = side_q;
    assign bus.valid_out = valid_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             stall_inc, bubble_inc;

    always_comb begin
        stall_inc    = !bus.req && bus.stall;
        bubble_inc   = bus.req || (!bus.stall && (bus.flush || !bus.valid_in));
        stall_cnt_d  = perf_clr ? '0 : (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = perf_clr ? '0 : (bubble_inc && !(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg in both HOLD_MODE settings
// (and the PIPE_STAGE_PERF_EN counters when that macro is defined).
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_if b0 ();
    pipe_stage_if b1 ();

`ifdef PIPE_STAGE_PERF_EN
    logic       perf_clr0 = 1'b0;
    logic       perf_clr1 = 1'b0;
    logic [3:0] sc0, bc0, sc1, bc1;
`endif

    pipe_stage_reg #(
        .HOLD_MODE(1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u0 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef PIPE_STAGE_PERF_EN
        .perf_clr(perf_clr0),
        .stall_cnt(sc0),
        .bubble_cnt(bc0),
`endif
        .bus(b0)
    );

    pipe_stage_reg #(
        .HOLD_MODE(0)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u1 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef PIPE_STAGE_PERF_EN
        .perf_clr(perf_clr1),
        .stall_cnt(sc1),
        .bubble_cnt(bc1),
`endif
        .bus(b1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        {b0.req, b0.stall, b0.flush, b0.slot_in, b0.valid_in} = '0;
        {b0.redirect_pc, b0.instr_in, b0.pc_in, b0.exc_in, b0.side_in} = '0;
        {b1.req, b1.stall, b1.flush, b1.slot_in, b1.valid_in} = '0;
        {b1.redirect_pc, b1.instr_in, b1.pc_in, b1.exc_in, b1.side_in} = '0;
        #13 rst_n = 1'b0;
        #1;
        chk("rst_pc", b0.pc_out, 64'h3000);
        chk("rst_valid", b0.valid_out, 0);
        chk("rst_instr", b0.instr_out, 0);
        chk("rst_exc", b0.exc_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b0.pc_in = 32'h3004;
        b0.valid_in = 1'b1;
        tick;
        chk("adv_pc", b0.pc_out, 64'h3004);
        chk("adv_valid", b0.valid_out, 1);
        b0.instr_in = 32'h8C01_0004;
        #1;
        chk("adv_instr_pass", b0.instr_out, 64'h8C01_0004);
        b0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            b0.instr_in = 32'hFFFF_FFFF;
            #1;
            chk("stall_instr_hold", b0.instr_out, 64'h8C01_0004);
            chk("stall_pc_hold", b0.pc_out, 64'h3004);
        end
        b0.stall = 1'b0;
        b0.pc_in = 32'h3008;
        tick;
        chk("rel_pc", b0.pc_out, 64'h3008);
        b0.instr_in = 32'h1234_5678;
        #1;
        chk("rel_instr_follow", b0.instr_out, 64'h1234_5678);
        b0.flush = 1'b1;
        b0.redirect_pc = 32'h3100;
        b0.exc_in = 5'd4;
        b0.slot_in = 1'b1;
        b0.side_in = 1'b1;
        tick;
        chk("fl_pc", b0.pc_out, 64'h3100);
        chk("fl_exc", b0.exc_out, 4);
        chk("fl_valid", b0.valid_out, 0);
        chk("fl_slot", b0.slot_out, 0);
        chk("fl_side", b0.side_out, 0);
        chk("fl_instr", b0.instr_out, 0);
        b0.flush = 1'b0;
        b0.pc_in = 32'h3200;
        b0.exc_in = 5'd2;
        tick;
        b0.instr_in = 32'hAAAA_5555;
        #1;
        chk("adv2_slot", b0.slot_out, 1);
        chk("adv2_side", b0.side_out, 1);
        b0.stall = 1'b1;
        b0.flush = 1'b1;
        b0.redirect_pc = 32'h3300;
        b0.pc_in = 32'h3400;
        tick;
        b0.instr_in = 32'h0;
        #1;
        chk("sf_pc", b0.pc_out, 64'h3200);
        chk("sf_exc", b0.exc_out, 2);
        chk("sf_valid", b0.valid_out, 1);
        chk("sf_slot", b0.slot_out, 1);
        chk("sf_instr", b0.instr_out, 64'hAAAA_5555);
        b0.req = 1'b1;
        tick;
        chk("req_pc", b0.pc_out, 64'h4180);
        chk("req_exc", b0.exc_out, 0);
        chk("req_valid", b0.valid_out, 0);
        chk("req_slot", b0.slot_out, 0);
        chk("req_instr", b0.instr_out, 0);
        {b0.req, b0.stall, b0.flush} = '0;

        chk("h0_before", b1.instr_out, 0);
        b1.instr_in = 32'h0022_1820;
        b1.pc_in = 32'h3010;
        b1.valid_in = 1'b1;
        #1;
        chk("h0_no_comb", b1.instr_out, 0);
        tick;
        chk("h0_latency", b1.instr_out, 64'h0022_1820);
        chk("h0_pc", b1.pc_out, 64'h3010);
        b1.instr_in = 32'hDEAD_BEEF;
        b1.stall = 1'b1;
        tick;
        chk("h0_stall1", b1.instr_out, 64'h0022_1820);
        tick;
        chk("h0_stall2", b1.instr_out, 64'h0022_1820);
        b1.stall = 1'b0;
        tick;
        chk("h0_release", b1.instr_out, 64'hDEAD_BEEF);

`ifdef PIPE_STAGE_PERF_EN
        b0.valid_in = 1'b1;
        b0.stall = 1'b1;
        perf_clr0 = 1'b1;
        tick;
        chk("pc_clr_stall", sc0, 0);
        perf_clr0 = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        chk("pc_stall_sat", sc0, 15);
        b0.stall = 1'b0;
        perf_clr0 = 1'b1;
        tick;
        chk("pc_clr_stall2", sc0, 0);
        chk("pc_clr_bub", bc0, 0);
        perf_clr0 = 1'b0;
        b0.flush = 1'b1;
        tick;
        tick;
        b0.flush = 1'b0;
        b0.valid_in = 1'b0;
        tick;
        chk("pc_bubble", bc0, 3);
        chk("pc_stall_idle", sc0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
